// File: rtl/reg_file_mp_pkg.sv
// ---------------------------------------------------------------------------
// reg_file_mp_pkg
// Shared types and helpers for the multi-port register file.
//  - DEF_* localparams give the integer-pipeline default geometry and the
//    reg_addr_t / reg_data_t typedefs built from them.
//  - onehot_prio_sel() returns the index of the highest set bit of a
//    request vector; used to pick the youngest write port.
// ---------------------------------------------------------------------------
package reg_file_mp_pkg;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_NUM_REGS   = 32;
    localparam int DEF_AW         = $clog2(DEF_NUM_REGS);

    // Widest request vector onehot_prio_sel() accepts; write-port counts
    // are far below this in any realistic pipeline.
    localparam int PRIO_MAX = 32;

    typedef logic [DEF_AW-1:0]         reg_addr_t;
    typedef logic [DEF_DATA_WIDTH-1:0] reg_data_t;

    // Highest set bit wins; returns 0 for an all-zero vector, so callers
    // must qualify the result with their own "any hit" flag.
    function automatic int onehot_prio_sel(input logic [PRIO_MAX-1:0] vec);
        int idx;
        idx = 0;
        for (int i = 0; i < PRIO_MAX; i++) begin
            if (vec[i]) begin
                idx = i;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/reg_file_mp_if.sv
// ---------------------------------------------------------------------------
// reg_file_mp_if
// Bundle of the register file's read/write bus signals.
//  r_addr_i       read addresses, one per read port
//  r_data_o       read data, one per read port
//  w_addr_i       write addresses, one per write port
//  w_data_i       write data, one per write port
//  w_en_i         write enables, one per write port
//  conflict_o     previous cycle had a same-register write collision
//  conflict_cnt_o saturating count of collision cycles
// Handshake: there is no valid/ready pair. Every read port is always
// serviced; a write port transfers exactly in the cycles where its w_en_i is
// high, and the register file can never stall it. Suffixes are relative to
// the register file (slave side).
// ---------------------------------------------------------------------------
interface reg_file_mp_if #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 32,
    parameter int NUM_RPORT  = 4,
    parameter int NUM_WPORT  = 2,
    parameter int CNT_WIDTH  = 16
);
    localparam int AW = $clog2(NUM_REGS);

    logic [NUM_RPORT-1:0][AW-1:0]         r_addr_i;
    logic [NUM_RPORT-1:0][DATA_WIDTH-1:0] r_data_o;
    logic [NUM_WPORT-1:0][AW-1:0]         w_addr_i;
    logic [NUM_WPORT-1:0][DATA_WIDTH-1:0] w_data_i;
    logic [NUM_WPORT-1:0]                 w_en_i;
    logic                                 conflict_o;
    logic [CNT_WIDTH-1:0]                 conflict_cnt_o;

    // Issue/writeback side.
    modport master (
        output r_addr_i, w_addr_i, w_data_i, w_en_i,
        input  r_data_o, conflict_o, conflict_cnt_o
    );

    // Register file side.
    modport slave (
        input  r_addr_i, w_addr_i, w_data_i, w_en_i,
        output r_data_o, conflict_o, conflict_cnt_o
    );

endinterface

// File: rtl/reg_file_mp_wsel.sv
// ---------------------------------------------------------------------------
// reg_file_mp_wsel
// Write-port selector for one address. Used once per architectural register
// (commit path) and once per read port (bypass path).
//  match_addr_i  address this selector watches
//  w_addr_i      write addresses of all write ports
//  w_data_i      write data of all write ports
//  w_en_i        write enables of all write ports
//  hit_o         at least one effective write targets match_addr_i
//  multi_hit_o   two or more effective writes target match_addr_i
//  data_o        data of the highest-index matching port, 0 when no hit
// A write to address 0 is never effective, so r0 can never hit.
// ---------------------------------------------------------------------------
module reg_file_mp_wsel
    import reg_file_mp_pkg::*;
#(
    parameter int NUM_WPORT  = 2,
    parameter int AW         = 5,
    parameter int DATA_WIDTH = 32
) (
    input  logic [AW-1:0]                         match_addr_i,
    input  logic [NUM_WPORT-1:0][AW-1:0]          w_addr_i,
    input  logic [NUM_WPORT-1:0][DATA_WIDTH-1:0]  w_data_i,
    input  logic [NUM_WPORT-1:0]                  w_en_i,
    output logic                                  hit_o,
    output logic                                  multi_hit_o,
    output logic [DATA_WIDTH-1:0]                 data_o
);

    logic [NUM_WPORT-1:0] match;
    int                   sel_idx;

    always_comb begin
        match       = '0;
        hit_o       = 1'b0;
        multi_hit_o = 1'b0;
        data_o      = '0;
        sel_idx     = 0;

        for (int p = 0; p < NUM_WPORT; p++) begin
            match[p] = w_en_i[p] && (w_addr_i[p] == match_addr_i) &&
                       (w_addr_i[p] != '0);
        end

        for (int p = 0; p < NUM_WPORT; p++) begin
            if (match[p]) begin
                if (hit_o) begin
                    multi_hit_o = 1'b1;
                end
                hit_o = 1'b1;
            end
        end

        sel_idx = onehot_prio_sel(PRIO_MAX'(match));

        // Data is only ever taken from a port whose enable is set, so
        // undriven data on idle ports cannot leak into the result.
        for (int p = 0; p < NUM_WPORT; p++) begin
            if (hit_o && (sel_idx == p)) begin
                data_o = w_data_i[p];
            end
        end
    end

endmodule

// File: rtl/reg_file_mp.sv
// ---------------------------------------------------------------------------
// reg_file_mp
// Multi-port general-purpose register file for the integer pipeline.
//  clk    clock, all state updates on the rising edge
//  rst_n  synchronous active-low reset; clears the array, the collision
//         flag/counter and the registered read data, discarding any writes
//         presented in the reset cycle
//  bus    reg_file_mp_if.slave: read ports, write ports, collision status
// Behaviour summary:
//  - r0 reads as zero and is not stored; writes to it are dropped.
//  - Same-register writes in one cycle: the highest-index port wins, the
//    next cycle shows conflict_o=1 and the counter advances once.
//  - BYPASS=1 forwards same-cycle write data to matching reads.
//  - READ_LATENCY=1 registers the read value (bypass rule applied first).
// ---------------------------------------------------------------------------
module reg_file_mp
    import reg_file_mp_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int NUM_REGS     = 32,
    parameter int NUM_RPORT    = 4,
    parameter int NUM_WPORT    = 2,
    parameter int BYPASS       = 1,
    parameter int READ_LATENCY = 0,
    parameter int CNT_WIDTH    = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    reg_file_mp_if.slave bus
);

    localparam int AW = $clog2(NUM_REGS);

    // ---------------------------------------------------------------
    // Storage: entries 1..NUM_REGS-1 only, r0 has no flops.
    // ---------------------------------------------------------------
    logic [DATA_WIDTH-1:0] regs_q [1:NUM_REGS-1];
    logic [DATA_WIDTH-1:0] regs_d [1:NUM_REGS-1];

    logic [NUM_REGS-1:1]   wr_hit;
    logic [NUM_REGS-1:1]   wr_multi;
    logic [DATA_WIDTH-1:0] wr_data [1:NUM_REGS-1];

    for (genvar k = 1; k < NUM_REGS; k++) begin : g_wsel
        reg_file_mp_wsel #(
            .NUM_WPORT  (NUM_WPORT),
            .AW         (AW),
            .DATA_WIDTH (DATA_WIDTH)
        ) u_wsel (
            .match_addr_i (AW'(k)),
            .w_addr_i     (bus.w_addr_i),
            .w_data_i     (bus.w_data_i),
            .w_en_i       (bus.w_en_i),
            .hit_o        (wr_hit[k]),
            .multi_hit_o  (wr_multi[k]),
            .data_o       (wr_data[k])
        );
    end

    always_comb begin
        regs_d = regs_q;
        for (int k = 1; k < NUM_REGS; k++) begin
            if (wr_hit[k]) begin
                regs_d[k] = wr_data[k];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 1; k < NUM_REGS; k++) begin
                regs_q[k] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    // ---------------------------------------------------------------
    // Collision flag and saturating counter. Any number of colliding
    // registers in one cycle counts as a single event.
    // ---------------------------------------------------------------
    logic                 any_conflict;
    logic                 conflict_q;
    logic                 conflict_d;
    logic [CNT_WIDTH-1:0] conflict_cnt_q;
    logic [CNT_WIDTH-1:0] conflict_cnt_d;

    assign any_conflict = |wr_multi;

    always_comb begin
        conflict_d     = any_conflict;
        conflict_cnt_d = conflict_cnt_q;
        if (any_conflict && (conflict_cnt_q != '1)) begin
            conflict_cnt_d = conflict_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            conflict_q     <= 1'b0;
            conflict_cnt_q <= '0;
        end else begin
            conflict_q     <= conflict_d;
            conflict_cnt_q <= conflict_cnt_d;
        end
    end

    assign bus.conflict_o     = conflict_q;
    assign bus.conflict_cnt_o = conflict_cnt_q;

    // ---------------------------------------------------------------
    // Read path: per-port bypass selector (only when BYPASS=1), then a
    // mux over the stored entries.
    // ---------------------------------------------------------------
    logic [NUM_RPORT-1:0]                 rd_byp_hit;
    logic [NUM_RPORT-1:0][DATA_WIDTH-1:0] rd_byp_data;
    logic [NUM_RPORT-1:0][DATA_WIDTH-1:0] rdata_d;

    if (BYPASS != 0) begin : g_byp
        logic [NUM_RPORT-1:0] rd_multi_unused;
        for (genvar r = 0; r < NUM_RPORT; r++) begin : g_rport
            reg_file_mp_wsel #(
                .NUM_WPORT  (NUM_WPORT),
                .AW         (AW),
                .DATA_WIDTH (DATA_WIDTH)
            ) u_byp_sel (
                .match_addr_i (bus.r_addr_i[r]),
                .w_addr_i     (bus.w_addr_i),
                .w_data_i     (bus.w_data_i),
                .w_en_i       (bus.w_en_i),
                .hit_o        (rd_byp_hit[r]),
                .multi_hit_o  (rd_multi_unused[r]),
                .data_o       (rd_byp_data[r])
            );
        end
    end else begin : g_nobyp
        assign rd_byp_hit  = '0;
        assign rd_byp_data = '0;
    end

    always_comb begin
        rdata_d = '0;
        for (int r = 0; r < NUM_RPORT; r++) begin
            if (bus.r_addr_i[r] != '0) begin
                if (rd_byp_hit[r]) begin
                    rdata_d[r] = rd_byp_data[r];
                end else begin
                    for (int k = 1; k < NUM_REGS; k++) begin
                        if (bus.r_addr_i[r] == AW'(k)) begin
                            rdata_d[r] = regs_q[k];
                        end
                    end
                end
            end
        end
    end

    if (READ_LATENCY != 0) begin : g_rreg
        logic [NUM_RPORT-1:0][DATA_WIDTH-1:0] rdata_q;

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                rdata_q <= '0;
            end else begin
                rdata_q <= rdata_d;
            end
        end

        assign bus.r_data_o = rdata_q;
    end else begin : g_rcomb
        assign bus.r_data_o = rdata_d;
    end

endmodule
